// File: rtl/rom_fetch_ctrl.sv
// Burst read initiator for the synchronous ROM model: issues addresses, captures data one cycle later,
// buffers beats in a small FIFO and streams them out. Define ROM_FETCH_CSUM_EN to add the csum output.
module rom_fetch_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int DATA_SIZE  = 1,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 8,
  parameter int FIFO_DEPTH = 4,
  localparam int DATA_LEN  = DATA_SIZE * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LEN_WIDTH-1:0]  req_len,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_LEN-1:0]   rom_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_LEN-1:0]   out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
`ifdef ROM_FETCH_CSUM_EN
  ,
  output logic [DATA_LEN-1:0]   csum
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] romAddr_q;
  logic [ADDR_WIDTH-1:0] romAddr_d;
  logic [LEN_WIDTH-1:0]  remaining_q;
  logic [LEN_WIDTH-1:0]  remaining_d;
  logic                  inflight_q;
  logic                  inflightLast_q;
  logic                  done_q;

  logic [DATA_LEN-1:0]   memData_q [FIFO_DEPTH];
  logic                  memLast_q [FIFO_DEPTH];
  logic [PW-1:0]         wrPtr_q;
  logic [PW-1:0]         rdPtr_q;
  logic [CW-1:0]         count_q;

  logic accept;
  logic issue;
  logic room;
  logic push;
  logic pop;
  logic lastIssue;

  // Room is judged on the registered count plus the beat still in the ROM pipe, so
  // a pop in the same cycle is never relied upon and the FIFO cannot overflow.
  assign room      = ({1'b0, count_q} + {{CW{1'b0}}, inflight_q}) < (CW+1)'(FIFO_DEPTH);
  assign accept    = req_valid && (state_q == IDLE);
  assign issue     = (state_q == FETCH) && room;
  assign lastIssue = issue && (remaining_q == LEN_WIDTH'(1));
  assign push      = inflight_q;
  assign pop       = out_valid && out_ready;

  assign romAddr_d   = romAddr_q + ADDR_WIDTH'(DATA_SIZE);
  assign remaining_d = remaining_q - LEN_WIDTH'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      romAddr_q      <= '0;
      remaining_q    <= '0;
      inflight_q     <= 1'b0;
      inflightLast_q <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      done_q         <= 1'b0;
      inflight_q     <= issue;
      inflightLast_q <= lastIssue;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (req_len != '0) begin
              romAddr_q   <= req_addr;
              remaining_q <= req_len;
              state_q     <= FETCH;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (issue) begin
            romAddr_q   <= romAddr_d;
            remaining_q <= remaining_d;
            if (lastIssue) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if ((count_q == '0) && !inflight_q) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        memData_q[i] <= '0;
        memLast_q[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        memData_q[wrPtr_q] <= rom_data;
        memLast_q[wrPtr_q] <= inflightLast_q;
        wrPtr_q            <= wrPtr_q + PW'(1);
      end
      if (pop) begin
        rdPtr_q <= rdPtr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef ROM_FETCH_CSUM_EN
  logic [DATA_LEN-1:0] csum_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum_q <= '0;
    end else if (accept) begin
      csum_q <= '0;
    end else if (pop) begin
      csum_q <= csum_q ^ out_data;
    end
  end

  assign csum = csum_q;
`endif

  // The head is gated so an empty FIFO shows zeros rather than a stale beat.
  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? memData_q[rdPtr_q] : '0;
  assign out_last  = out_valid ? memLast_q[rdPtr_q] : 1'b0;
  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign rom_addr  = romAddr_q;

endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// Scoreboard bench for rom_fetch_ctrl: directed test-plan bursts followed by randomized bursts
// with random back-pressure; checks csum too when ROM_FETCH_CSUM_EN is defined.
module tb_rom_fetch_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] req_addr = '0;
  logic [7:0] req_len = '0;
  logic [7:0] rom_addr;
  logic [7:0] rom_data = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_last;
  logic       busy;
  logic       done;
`ifdef ROM_FETCH_CSUM_EN
  logic [7:0] csum;
`endif

  rom_fetch_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
`ifdef ROM_FETCH_CSUM_EN
    ,
    .csum      (csum)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous ROM: address sampled at a posedge, data visible for the following cycle.
  logic [7:0] rom [256];
  always @(posedge clk) rom_data <= rom[rom_addr];

  typedef struct {
    logic [7:0] data;
    logic       last;
  } beat_t;

  beat_t expQ[$];
  int    compared = 0;
  int    mismatched = 0;
  int    doneCount = 0;
  int    expDone = 0;
  int    xferCount = 0;
  logic [7:0] expCsum = '0;
  bit    randReady = 0;
  bit    fixedReady = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = randReady ? ($urandom_range(0, 3) != 0) : fixedReady;
    end
  end

  // Monitor: every transferred beat is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        xferCount++;
        checkOutput("scoreboard has beat", 32'(expQ.size() != 0), 1);
        if (expQ.size() != 0) begin
          beat_t b;
          b = expQ.pop_front();
          checkOutput("out_data", 32'(out_data), 32'(b.data));
          checkOutput("out_last", 32'(out_last), 32'(b.last));
        end
      end
      if (done) begin
        doneCount++;
        checkOutput("queue empty at done", 32'(expQ.size()), 0);
      end
    end
  end

  // Issue one request and record its expected beats at the accept edge.
  task automatic applyStimulus(input logic [7:0] addr, input logic [7:0] len);
    bit got = 0;
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_addr  = addr;
    req_len   = len;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      got = req_ready;
    end
    if (!got) begin
      checkOutput("request accept timeout", 0, 1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    expCsum = '0;
    for (int i = 0; i < int'(len); i++) begin
      beat_t b;
      b.data = rom[8'(int'(addr) + i)];
      b.last = (i == int'(len) - 1);
      expQ.push_back(b);
      expCsum = expCsum ^ b.data;
    end
    expDone++;
    #1;
    req_valid = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    bit seen = 0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge clk);
      seen = done;
    end
    checkOutput("done within budget", 32'(seen), 1);
`ifdef ROM_FETCH_CSUM_EN
    if (seen) checkOutput("csum at done", 32'(csum), 32'(expCsum));
`endif
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " rom_addr"}, 32'(rom_addr), 0);
    checkOutput({tag, " out_valid"}, 32'(out_valid), 0);
    checkOutput({tag, " out_data"}, 32'(out_data), 0);
    checkOutput({tag, " out_last"}, 32'(out_last), 0);
    checkOutput({tag, " busy"}, 32'(busy), 0);
    checkOutput({tag, " done"}, 32'(done), 0);
    checkOutput({tag, " req_ready"}, 32'(req_ready), 1);
  endtask

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    mismatched++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int d0;
    int base;
    bit reached;
    for (int k = 0; k < 256; k++) rom[k] = 8'(k);

    #1 rst = 1'b1;
    #1 checkResetValues("reset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Burst of 3 at full rate: latency, ordering and last tag.
    fixedReady = 1;
    repeat (2) @(posedge clk);
    d0 = doneCount;
    applyStimulus(8'h03, 8'd3);
    @(negedge clk) checkOutput("t1 out_valid accept+1", 32'(out_valid), 0);
    @(negedge clk) checkOutput("t1 out_valid accept+2", 32'(out_valid), 0);
    @(negedge clk);
    checkOutput("t1 first valid", 32'(out_valid), 1);
    checkOutput("t1 beat0", 32'(out_data), 32'h03);
    checkOutput("t1 beat0 last", 32'(out_last), 0);
    @(negedge clk);
    checkOutput("t1 beat1", 32'(out_data), 32'h04);
    @(negedge clk);
    checkOutput("t1 beat2", 32'(out_data), 32'h05);
    checkOutput("t1 beat2 last", 32'(out_last), 1);
    waitDone(50);
    repeat (3) @(negedge clk);
    checkOutput("t1 single done", 32'(doneCount - d0), 1);

    // Back-pressure: FIFO fills and the address stops advancing.
    fixedReady = 0;
    repeat (2) @(posedge clk);
    applyStimulus(8'h10, 8'd8);
    repeat (20) @(negedge clk);
    checkOutput("t2 rom_addr stalled", 32'(rom_addr), 32'h14);
    checkOutput("t2 out_valid held", 32'(out_valid), 1);
    checkOutput("t2 head beat", 32'(out_data), 32'h10);
    fixedReady = 1;
    waitDone(100);

    // Address wrap.
    applyStimulus(8'hFE, 8'd4);
    waitDone(100);
    checkOutput("t3 rom_addr wrapped", 32'(rom_addr), 32'h02);

    // Zero-length request.
    applyStimulus(8'h40, 8'd0);
    @(negedge clk);
    checkOutput("t4 done", 32'(done), 1);
    checkOutput("t4 busy", 32'(busy), 0);
    checkOutput("t4 out_valid", 32'(out_valid), 0);
    @(negedge clk);
    checkOutput("t4 done one cycle", 32'(done), 0);

`ifdef ROM_FETCH_CSUM_EN
    applyStimulus(8'h01, 8'd4);
    waitDone(100);
    checkOutput("csum directed", 32'(csum), 32'h04);
`endif

    // Reset mid-burst discards everything.
    base = xferCount;
    applyStimulus(8'h30, 8'd6);
    reached = 0;
    for (int n = 0; n < 100 && !reached; n++) begin
      @(negedge clk);
      reached = (xferCount >= base + 2);
    end
    checkOutput("t5 two beats seen", 32'(reached), 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 checkResetValues("mid-burst reset");
    expQ.delete();
    expDone--;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    applyStimulus(8'h20, 8'd2);
    waitDone(100);

    // Randomized bursts with random back-pressure and ROM contents.
    randReady = 1;
    for (int t = 0; t < 30; t++) begin
      if (t % 6 == 0) begin
        for (int k = 0; k < 256; k++) rom[k] = 8'($urandom);
      end
      applyStimulus(8'($urandom), 8'($urandom_range(0, 12)));
      waitDone(500);
    end
    randReady = 0;

    repeat (5) @(negedge clk);
    checkOutput("total done pulses", 32'(doneCount), 32'(expDone));
    checkOutput("scoreboard drained", 32'(expQ.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/rom_fetch_ctrl.md
Name: rom_fetch_ctrl

Overview:
Read-side initiator for the team's synchronous ROM model. It takes a burst request (start address, beat count), drives the ROM address port and captures ROM data one cycle later. Captured words are buffered in a small FIFO and presented on a valid/ready stream. It sits between a ROM instance and any DV consumer, such as an instruction-fetch stub or a boot loader model.

Parameters:
DATA_WIDTH, 8, bits per ROM word
DATA_SIZE, 1, ROM words returned per read; beat width DATA_LEN = DATA_SIZE*DATA_WIDTH
ADDR_WIDTH, 8, ROM address width
LEN_WIDTH, 8, width of the burst beat count
FIFO_DEPTH, 4, output buffer depth in beats; power of two, >= 2

Ports:
clk  in  1  clock; all state changes on posedge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  burst request valid
req_ready  out  1  high in IDLE only
req_addr  in  ADDR_WIDTH  burst start address (ROM word index)
req_len  in  LEN_WIDTH  number of beats; 0 is legal
rom_addr  out  ADDR_WIDTH  registered address to ROM
rom_data  in  DATA_LEN  ROM registered read data
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer accepts beat
out_data  out  DATA_LEN  FIFO head beat
out_last  out  1  head beat is the final beat of the burst
busy  out  1  state != IDLE
done  out  1  one-cycle pulse when a burst completes

Behaviour:
- Reset values: rom_addr=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0, req_ready=1. FIFO is emptied, in-flight flag cleared, state=IDLE.
- Reset mid-burst discards every buffered and in-flight beat. No done pulse is produced for the aborted burst.
- ROM timing contract: the ROM samples rom_addr at posedge E and exposes rom_data during the cycle after E. The block captures rom_data at the next posedge.
- Handshakes: a request is accepted at a posedge where req_valid && req_ready. An output beat transfers at a posedge where out_valid && out_ready.
- Output stream: out_data/out_last must be held stable while out_valid && !out_ready.
- FSM:
  - IDLE: req_ready=1.
    - On accept with req_len!=0: rom_addr<=req_addr, remaining<=req_len, go to FETCH.
    - On accept with req_len==0: done=1 in the next cycle, stay IDLE.
  - FETCH: issue one beat each cycle where fifo_count + inflight < FIFO_DEPTH. On issue:
    - inflight<=1
    - remaining<=remaining-1
    - rom_addr<=rom_addr+DATA_SIZE (mod 2**ADDR_WIDTH; wraps, no error)
    - When the last beat is issued, go to DRAIN.
  - DRAIN: when FIFO is empty, inflight==0, and no push is pending: done=1 for one cycle, go to IDLE.
- Capture: if inflight was set by the previous cycle's issue, push rom_data into the FIFO. The push is tagged last if it was the final issued beat. Clear inflight unless a new issue occurs in the same cycle.
- Simultaneous push and pop are allowed in the same cycle; fifo_count is unchanged.
- Flow control: the issue check uses the registered fifo_count, so the FIFO never overflows. Full rate (one beat/cycle) is sustained while out_ready=1.
- Latency: first out_valid rises 2 posedges after the accept edge. rom_addr wraps within the block only; each DATA_SIZE group is consecutive from rom_addr.
- req_valid while busy is ignored (req_ready=0); the requester must hold it.

Optional Feature:
ROM_FETCH_CSUM_EN:
- Defined: adds output port csum (DATA_LEN bits, reset 0). At each accepted request it clears to 0. On every output transfer it becomes csum XOR out_data. The value is final and stable from the done pulse until the next accept.
- Undefined: no csum port and no checksum logic.

Test Plan:
- ROM rom[k]=k, DATA_SIZE=1; req_addr=0x03, req_len=3, out_ready=1 -> out_data 0x03, 0x04, 0x05 on consecutive cycles. First beat 2 edges after accept, out_last on 0x05, done pulses once after last transfer.
- req_addr=0x10, req_len=8, out_ready=0 for 20 cycles -> fifo holds 4 beats, rom_addr stops advancing at 0x14. Then out_ready=1 -> 0x10..0x17 in order, no loss or duplication.
- req_addr=0xFE, req_len=4 -> out_data 0xFE, 0xFF, 0x00, 0x01; rom_addr wraps to 0x02.
- req_len=0 at addr 0x40 -> done pulses the cycle after accept, out_valid stays 0, busy stays 0.
- rst asserted after 2 beats of a len=6 burst -> all outputs at reset values immediately. Next request addr 0x20, len 2 -> exactly 0x20, 0x21, with no stale data.
- ROM_FETCH_CSUM_EN defined; rom[k]=k; addr 0x01, len 4 -> csum = 0x01^0x02^0x03^0x04 = 0x04 at done.
